// File: rtl/c3lib_strap_cfg_reg_lcell.sv
// Strap-defaulted configuration register: captures the tie bus after a settle
// window, then takes byte-enabled CSR writes/reloads and publishes via req/ack.
module c3lib_strap_cfg_reg_lcell #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   strap_in,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic               reload_req,
  input  logic               lock,
  input  logic               upd_ack,
  output logic [WIDTH-1:0]   cfg_out,
  output logic               upd_req,
  output logic               busy,
  output logic               wr_err
);

  localparam int NB = WIDTH / 8;

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_REQ    = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_nxt;
  logic [WIDTH-1:0] strap_q;
  logic [WIDTH-1:0] merged;
  logic             settling;
  logic             settle_done;
  logic             do_reload;
  logic             do_write;
  logic             accept;
  logic             reject;
  logic             ack_take;

  always_comb begin
    merged = shadow;
    for (int unsigned k = 0; k < NB; k++) begin
      if (wr_be[k]) merged[8*k +: 8] = wr_data[8*k +: 8];
    end
  end

  always_comb begin
    settling    = (state == ST_SETTLE);
    settle_done = settling && (cnt == CNT_W'(SETTLE_CYCLES - 1));
    // Reload has priority over a same-cycle write; the write is then reported as rejected.
    do_reload   = !settling && reload_req && !lock;
    do_write    = !settling && wr_en && !reload_req && !lock && (|wr_be);
    accept      = do_reload || do_write;
    reject      = settling ? (wr_en || reload_req)
                           : (((wr_en || reload_req) && lock) || (wr_en && reload_req));
    ack_take    = (state == ST_REQ) && upd_ack;

    shadow_nxt = shadow;
    if (settle_done)    shadow_nxt = strap_in;
    else if (do_reload) shadow_nxt = strap_q;
    else if (do_write)  shadow_nxt = merged;

    state_nxt = state;
    unique case (state)
      ST_SETTLE: if (settle_done) state_nxt = ST_REQ;
      ST_IDLE:   if (accept) state_nxt = ST_REQ;
      // An ack coinciding with an accepted update keeps REQ asserted: that
      // retained REQ is the dirty marker for the coalesced follow-up transfer.
      ST_REQ:    if (ack_take && !accept) state_nxt = ST_IDLE;
      default:   state_nxt = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_SETTLE;
      cnt     <= '0;
      shadow  <= '0;
      strap_q <= '0;
      cfg_out <= '0;
      upd_req <= 1'b0;
      busy    <= 1'b1;
      wr_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shadow  <= shadow_nxt;
      upd_req <= (state_nxt == ST_REQ);
      busy    <= (state_nxt != ST_IDLE);
      wr_err  <= reject;
      if (settling) cnt <= cnt + 1'b1;
      if (settle_done) strap_q <= strap_in;
      if (ack_take) cfg_out <= shadow;
    end
  end

endmodule

// File: tb/tb_c3lib_strap_cfg_reg_lcell.sv
// Bench for c3lib_strap_cfg_reg_lcell: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_c3lib_strap_cfg_reg_lcell;

  localparam int W  = 16;
  localparam int SC = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   strap_in;
  logic           wr_en;
  logic [W-1:0]   wr_data;
  logic [W/8-1:0] wr_be;
  logic           reload_req;
  logic           lock;
  logic           upd_ack;
  logic [W-1:0]   cfg_out;
  logic           upd_req;
  logic           busy;
  logic           wr_err;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int           m_settle_left;
  logic         m_pending;
  logic [W-1:0] m_shadow, m_strap, m_cfg;
  logic         m_err;

  c3lib_strap_cfg_reg_lcell #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .strap_in(strap_in), .wr_en(wr_en), .wr_data(wr_data),
    .wr_be(wr_be), .reload_req(reload_req), .lock(lock), .upd_ack(upd_ack),
    .cfg_out(cfg_out), .upd_req(upd_req), .busy(busy), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [W-1:0] mask;
    logic acc_rl, acc_wr;
    if (rst) begin
      m_settle_left = SC; m_pending = 0; m_shadow = '0; m_strap = '0; m_cfg = '0; m_err = 0;
    end else if (m_settle_left > 0) begin
      m_err = wr_en || reload_req;
      m_settle_left--;
      if (m_settle_left == 0) begin
        m_shadow = strap_in; m_strap = strap_in; m_pending = 1;
      end
    end else begin
      mask = '0;
      for (int k = 0; k < W/8; k++) if (wr_be[k]) mask[8*k +: 8] = 8'hFF;
      acc_rl = reload_req && !lock;
      acc_wr = wr_en && !reload_req && !lock && (mask != '0);
      m_err  = (wr_en || reload_req) && (lock || (wr_en && reload_req));
      if (m_pending && upd_ack) m_cfg = m_shadow;
      m_pending = (m_pending && !upd_ack) || acc_rl || acc_wr;
      if (acc_rl)      m_shadow = m_strap;
      else if (acc_wr) m_shadow = (m_shadow & ~mask) | (wr_data & mask);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_data = '0; wr_be = '0; reload_req = 0; lock = 0; upd_ack = 0;
  endtask

  task automatic test_reset();
    rst = 1; strap_in = 16'h0033; idle_inputs();
    cycle(); cycle();
    n_cmp++; if (cfg_out !== 16'h0000) begin n_bad++; $display("FAIL reset_cfg got %h want 0000", cfg_out); end
    n_cmp++; if ({upd_req, busy, wr_err} !== 3'b010) begin n_bad++; $display("FAIL reset_flags got %b want 010", {upd_req, busy, wr_err}); end
  endtask

  task automatic test_settle();
    int seen = 0;
    rst = 0;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      cycle();
      if (upd_req) seen = i;
    end
    n_cmp++; if (seen != SC) begin n_bad++; $display("FAIL settle_latency got %0d want %0d", seen, SC); end
    n_cmp++; if (cfg_out !== 16'h0000 || busy !== 1'b1) begin n_bad++; $display("FAIL settle_pre_ack got cfg=%h busy=%b want 0000/1", cfg_out, busy); end
    upd_ack = 1; cycle(); upd_ack = 0;
    n_cmp++; if (cfg_out !== 16'h0033) begin n_bad++; $display("FAIL settle_cfg got %h want 0033", cfg_out); end
    n_cmp++; if (upd_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL settle_idle got req=%b busy=%b want 0/0", upd_req, busy); end
  endtask

  task automatic test_byte_write();
    int high = 0;
    wr_en = 1; wr_data = 16'hABCD; wr_be = 2'b10; cycle(); idle_inputs();
    if (upd_req) high++;
    cycle(); if (upd_req) high++;
    cycle(); if (upd_req) high++;
    upd_ack = 1; cycle(); upd_ack = 0;
    if (upd_req) high++;
    n_cmp++; if (high != 3) begin n_bad++; $display("FAIL bw_req_cycles got %0d want 3", high); end
    n_cmp++; if (cfg_out !== 16'hAB33) begin n_bad++; $display("FAIL bw_cfg got %h want AB33", cfg_out); end
  endtask

  task automatic test_back_to_back();
    wr_en = 1; wr_data = 16'h2222; wr_be = 2'b01; cycle();
    wr_data = 16'h1111; wr_be = 2'b11; upd_ack = 1; cycle(); idle_inputs();
    n_cmp++; if (cfg_out !== 16'hAB22) begin n_bad++; $display("FAIL b2b_first_cfg got %h want AB22", cfg_out); end
    n_cmp++; if (upd_req !== 1'b1) begin n_bad++; $display("FAIL b2b_req_held got %b want 1", upd_req); end
    upd_ack = 1; cycle(); upd_ack = 0;
    n_cmp++; if (cfg_out !== 16'h1111 || upd_req !== 1'b0) begin n_bad++; $display("FAIL b2b_second got cfg=%h req=%b want 1111/0", cfg_out, upd_req); end
  endtask

  task automatic test_lock();
    int errs = 0;
    lock = 1; wr_en = 1; wr_data = 16'hFFFF; wr_be = 2'b11; cycle();
    if (wr_err) errs++;
    wr_en = 0; reload_req = 1; cycle();
    if (wr_err) errs++;
    idle_inputs(); cycle();
    n_cmp++; if (errs != 2 || wr_err !== 1'b0) begin n_bad++; $display("FAIL lock_err got %0d pulses end=%b want 2/0", errs, wr_err); end
    n_cmp++; if (cfg_out !== 16'h1111 || upd_req !== 1'b0) begin n_bad++; $display("FAIL lock_hold got cfg=%h req=%b want 1111/0", cfg_out, upd_req); end
  endtask

  task automatic test_reload_vs_write();
    reload_req = 1; wr_en = 1; wr_data = 16'hFFFF; wr_be = 2'b11; cycle(); idle_inputs();
    n_cmp++; if (wr_err !== 1'b1 || upd_req !== 1'b1) begin n_bad++; $display("FAIL rvw_pulse got err=%b req=%b want 1/1", wr_err, upd_req); end
    upd_ack = 1; cycle(); upd_ack = 0;
    n_cmp++; if (cfg_out !== 16'h0033 || wr_err !== 1'b0) begin n_bad++; $display("FAIL rvw_cfg got cfg=%h err=%b want 0033/0", cfg_out, wr_err); end
  endtask

  task automatic test_reset_mid_req();
    int seen = 0;
    wr_en = 1; wr_data = 16'h5555; wr_be = 2'b11; cycle(); idle_inputs();
    rst = 1; strap_in = 16'h00A5; upd_ack = 1; cycle(); upd_ack = 0;
    n_cmp++; if (cfg_out !== 16'h0000 || {upd_req, busy, wr_err} !== 3'b010) begin n_bad++; $display("FAIL rmr_reset got cfg=%h flags=%b want 0000/010", cfg_out, {upd_req, busy, wr_err}); end
    rst = 0;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      cycle();
      if (upd_req) seen = i;
    end
    n_cmp++; if (seen != SC) begin n_bad++; $display("FAIL rmr_latency got %0d want %0d", seen, SC); end
    upd_ack = 1; cycle(); upd_ack = 0;
    n_cmp++; if (cfg_out !== 16'h00A5) begin n_bad++; $display("FAIL rmr_cfg got %h want 00A5", cfg_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_data    = W'($urandom);
      wr_be      = (W/8)'($urandom);
      reload_req = ($urandom_range(0, 7) == 0);
      lock       = ($urandom_range(0, 3) == 0);
      upd_ack    = $urandom_range(0, 1) == 1;
      cycle();
      n_cmp++;
      if (cfg_out !== m_cfg || upd_req !== m_pending || wr_err !== m_err ||
          busy !== (m_pending || m_settle_left > 0)) begin
        n_bad++;
        $display("FAIL rand_%0d got cfg=%h req=%b busy=%b err=%b want cfg=%h req=%b busy=%b err=%b",
                 i, cfg_out, upd_req, busy, wr_err, m_cfg, m_pending,
                 (m_pending || m_settle_left > 0), m_err);
      end
    end
    rst = 0; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_settle();
    test_byte_write();
    test_back_to_back();
    test_lock();
    test_reload_vs_write();
    test_reset_mid_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
